// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants and types for the data-memory responder
package dmem_pkg;

    // MMIO register offsets, word index A[3:2] within the page
    localparam logic [1:0] OFF_LED  = 2'd0;
    localparam logic [1:0] OFF_CNT  = 2'd1;
    localparam logic [1:0] OFF_CMP  = 2'd2;
    localparam logic [1:0] OFF_STAT = 2'd3;

    // Returned for misaligned or unmapped reads
    localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

    // Status register bit positions
    localparam int STAT_TMR = 0;
    localparam int STAT_ERR = 1;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_MMIO,
        REG_NONE
    } region_e;

endpackage

// File: rtl/dmem_ram_array.sv
// rtl/dmem_ram_array.sv - word array with asynchronous read and synchronous write
//
// Ports:
//   clk    - write clock, rising edge
//   we     - write enable
//   waddr  - write word index
//   wdata  - write data
//   raddr  - read word index
//   rdata  - read data, combinational; returns the pre-write value
//            in a cycle that also writes the same word
module dmem_ram_array #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - MEM-stage data responder: data RAM plus MMIO page
//
// Ports:
//   CLOCK        - system clock, rising edge
//   RST_n        - asynchronous active-low reset
//   ena_rd       - read strobe from the MEM stage
//   ena_wr       - write strobe from the MEM stage
//   alu_out_ext  - byte address
//   dataram_wr   - write data
//   dataram_rd   - read data, combinational, zero when ena_rd is low
//   leds         - LED register
//   timer_irq    - sticky timer-match status bit
//   addr_err     - sticky address-error status bit
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter int          LED_W     = 8,
    parameter logic [31:0] MMIO_BASE = 32'h1000_0000
) (
    input  logic             CLOCK,
    input  logic             RST_n,
    input  logic             ena_rd,
    input  logic             ena_wr,
    input  logic [31:0]      alu_out_ext,
    input  logic [31:0]      dataram_wr,
    output logic [31:0]      dataram_rd,
    output logic [LED_W-1:0] leds,
    output logic             timer_irq,
    output logic             addr_err
);

    logic [LED_W-1:0] leds_q,   leds_d;
    logic [31:0]      cnt_q,    cnt_d;
    logic [31:0]      cmp_q,    cmp_d;
    logic [1:0]       status_q, status_d;

    region_e     region;
    logic        access_err;
    logic        wr_ok;
    logic        ram_we;
    logic [31:0] ram_rdata;
    logic [1:0]  offset;

    assign offset = alu_out_ext[3:2];

    always_comb begin
        region = REG_NONE;
        if (alu_out_ext[31:ADDR_W+2] == '0) begin
            region = REG_RAM;
        end else if (alu_out_ext[31:4] == MMIO_BASE[31:4]) begin
            region = REG_MMIO;
        end
    end

    // Any strobed access that is misaligned or lands outside both regions
    assign access_err = (ena_rd || ena_wr) &&
                        ((alu_out_ext[1:0] != 2'b00) || (region == REG_NONE));
    assign wr_ok      = ena_wr && (alu_out_ext[1:0] == 2'b00);
    assign ram_we     = wr_ok && (region == REG_RAM);

    dmem_ram_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (32)
    ) u_ram (
        .clk   (CLOCK),
        .we    (ram_we),
        .waddr (alu_out_ext[ADDR_W+1:2]),
        .wdata (dataram_wr),
        .raddr (alu_out_ext[ADDR_W+1:2]),
        .rdata (ram_rdata)
    );

    // Read mux sees only current register state, so a read paired with a
    // write to the same location returns the old value.
    always_comb begin
        dataram_rd = 32'h0;
        if (ena_rd) begin
            if ((alu_out_ext[1:0] != 2'b00) || (region == REG_NONE)) begin
                dataram_rd = ERR_RDATA;
            end else if (region == REG_RAM) begin
                dataram_rd = ram_rdata;
            end else begin
                case (offset)
                    OFF_LED:  dataram_rd = 32'(leds_q);
                    OFF_CNT:  dataram_rd = cnt_q;
                    OFF_CMP:  dataram_rd = cmp_q;
                    default:  dataram_rd = {30'h0, status_q};
                endcase
            end
        end
    end

    always_comb begin
        leds_d   = leds_q;
        cnt_d    = cnt_q + 32'd1;
        cmp_d    = cmp_q;
        status_d = status_q;

        if (wr_ok && (region == REG_MMIO)) begin
            case (offset)
                OFF_LED:  leds_d   = dataram_wr[LED_W-1:0];
                OFF_CNT:  cnt_d    = 32'h0;
                OFF_CMP:  cmp_d    = dataram_wr;
                default:  status_d = status_q & ~dataram_wr[1:0];
            endcase
        end

        // New events are applied after the W1C so that set wins
        if (cnt_q == cmp_q) begin
            status_d[STAT_TMR] = 1'b1;
        end
        if (access_err) begin
            status_d[STAT_ERR] = 1'b1;
        end
    end

    always_ff @(posedge CLOCK or negedge RST_n) begin
        if (!RST_n) begin
            leds_q   <= '0;
            cnt_q    <= 32'h0;
            cmp_q    <= 32'hFFFF_FFFF;
            status_q <= 2'b00;
        end else begin
            leds_q   <= leds_d;
            cnt_q    <= cnt_d;
            cmp_q    <= cmp_d;
            status_q <= status_d;
        end
    end

    assign leds      = leds_q;
    assign timer_irq = status_q[STAT_TMR];
    assign addr_err  = status_q[STAT_ERR];

endmodule
